// File: rtl/pio_pkg.sv
// Shared constants and helpers for the PIO fetch/issue slice.
// Opcodes, delay-field location and the side-set delay mask.
package pio_pkg;

  localparam int ADDR_W            = 5;
  localparam int INSTR_W           = 16;
  localparam int DELAY_LSB         = 8;
  localparam int DELAY_MSB         = 12;
  localparam int DELAY_W           = DELAY_MSB - DELAY_LSB + 1;
  localparam int MAX_SIDESET_DELAY = 5;

  typedef enum logic [2:0] {
    OP_JMP      = 3'd0,
    OP_WAIT     = 3'd1,
    OP_IN       = 3'd2,
    OP_OUT      = 3'd3,
    OP_PUSHPULL = 3'd4,
    OP_MOV      = 3'd5,
    OP_IRQ      = 3'd6,
    OP_SET      = 3'd7
  } opcode_e;

  // Side-set bits steal the top of the delay field.
  function automatic logic [DELAY_W-1:0] delay_mask(
    input logic [2:0] ss
  );
    logic [2:0] n;
    logic [5:0] m;
    n = (ss > 3'd5) ? 3'd5 : ss;
    m = (6'd1 << (3'd5 - n)) - 6'd1;
    return m[DELAY_W-1:0];
  endfunction

endpackage

// File: rtl/pio_imem.sv
// 32x16 instruction memory: async clear, one write port,
// one combinational read port.
module pio_imem
  import pio_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pio_fetch.sv
// PIO fetch/issue stage: instruction memory, forced-instruction
// holding register and per-instruction delay counter.
module pio_fetch
  import pio_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               penable,
  input  logic               sm_restart,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               stalled_in,
  input  logic [2:0]         sideset_bits,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_waddr,
  input  logic [INSTR_W-1:0] mem_wdata,
  input  logic               imm_valid,
  input  logic [INSTR_W-1:0] imm_instr,
  output logic               imm_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               is_imm,
  output logic               issue,
  output logic               delay_busy
);

  logic [INSTR_W-1:0] mem_rdata;
  logic               imm_pend_q, imm_pend_d;
  logic [INSTR_W-1:0] imm_buf_q, imm_buf_d;
  logic [DELAY_W-1:0] delay_q, delay_d;

  pio_imem u_imem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr   (pc),
    .rdata   (mem_rdata)
  );

  assign imm_ready  = !imm_pend_q;
  assign is_imm     = imm_pend_q;
  assign instr      = imm_pend_q ? imm_buf_q : mem_rdata;
  assign delay_busy = (delay_q != '0);

  // Forced instructions bypass both penable and any pending delay.
  assign issue = !stalled_in &&
                 (imm_pend_q || (penable && delay_q == '0));

  always_comb begin
    imm_pend_d = imm_pend_q;
    imm_buf_d  = imm_buf_q;
    delay_d    = delay_q;

    if (imm_pend_q) begin
      if (issue) imm_pend_d = 1'b0;
    end else if (imm_valid) begin
      imm_pend_d = 1'b1;
      imm_buf_d  = imm_instr;
    end

    // A pending forced instruction freezes the countdown.
    if (sm_restart) begin
      delay_d = '0;
    end else if (!imm_pend_q) begin
      if (issue) begin
        delay_d = instr[DELAY_MSB:DELAY_LSB] &
                  delay_mask(sideset_bits);
      end else if (penable && delay_q != '0) begin
        delay_d = delay_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imm_pend_q <= 1'b0;
      imm_buf_q  <= '0;
      delay_q    <= '0;
    end else begin
      imm_pend_q <= imm_pend_d;
      imm_buf_q  <= imm_buf_d;
      delay_q    <= delay_d;
    end
  end

endmodule

// File: tb/tb_pio_fetch.sv
// Directed bench for pio_fetch: memory issue, delays,
// forced instructions, restart and async reset.
module tb_pio_fetch;

  logic        clk;
  logic        reset_n;
  logic        penable;
  logic        sm_restart;
  logic [4:0]  pc;
  logic        stalled_in;
  logic [2:0]  sideset_bits;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        imm_valid;
  logic [15:0] imm_instr;
  logic        imm_ready;
  logic [15:0] instr;
  logic        is_imm;
  logic        issue;
  logic        delay_busy;

  int vectors;
  int miscompares;

  pio_fetch dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .penable      (penable),
    .sm_restart   (sm_restart),
    .pc           (pc),
    .stalled_in   (stalled_in),
    .sideset_bits (sideset_bits),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .imm_valid    (imm_valid),
    .imm_instr    (imm_instr),
    .imm_ready    (imm_ready),
    .instr        (instr),
    .is_imm       (is_imm),
    .issue        (issue),
    .delay_busy   (delay_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic pe, input logic ei,
                     input logic eb, input string tag);
    penable = pe;
    #1;
    chk({tag, "_issue"}, 16'(issue), 16'(ei));
    chk({tag, "_busy"}, 16'(delay_busy), 16'(eb));
    tick();
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset_n      = 1'b0;
    penable      = 1'b0;
    sm_restart   = 1'b0;
    pc           = 5'd0;
    stalled_in   = 1'b0;
    sideset_bits = 3'd0;
    mem_we       = 1'b0;
    mem_waddr    = 5'd0;
    mem_wdata    = 16'h0000;
    imm_valid    = 1'b0;
    imm_instr    = 16'h0000;
    #2;
    chk("rst_ready", 16'(imm_ready), 16'd1);
    chk("rst_is_imm", 16'(is_imm), 16'd0);
    chk("rst_issue", 16'(issue), 16'd0);
    chk("rst_busy", 16'(delay_busy), 16'd0);
    chk("rst_instr", instr, 16'h0000);
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    // write to the word being read: old value this cycle
    pc        = 5'd3;
    mem_we    = 1'b1;
    mem_waddr = 5'd3;
    mem_wdata = 16'hE001;
    #1 chk("wr_old", instr, 16'h0000);
    tick();
    mem_we = 1'b0;
    #1 chk("wr_new", instr, 16'hE001);
    chk("e001_is_imm", 16'(is_imm), 16'd0);
    cyc(1, 1, 0, "e001_a");
    cyc(1, 1, 0, "e001_b");

    penable   = 1'b0;
    mem_we    = 1'b1;
    mem_waddr = 5'd0;
    mem_wdata = 16'h0300;
    tick();
    mem_waddr = 5'd1;
    mem_wdata = 16'h0400;
    tick();
    mem_waddr = 5'd2;
    mem_wdata = 16'h1F00;
    tick();
    mem_we = 1'b0;

    // delay 3, penable every other cycle
    pc         = 5'd0;
    stalled_in = 1'b1;
    cyc(1, 0, 0, "stall_mem");
    stalled_in = 1'b0;
    cyc(1, 1, 0, "d3_issue");
    cyc(0, 0, 1, "d3_c1");
    cyc(1, 0, 1, "d3_p1");
    cyc(0, 0, 1, "d3_c2");
    cyc(1, 0, 1, "d3_p2");
    cyc(0, 0, 1, "d3_c3");
    cyc(1, 0, 1, "d3_p3");
    cyc(0, 0, 0, "d3_c4");
    cyc(1, 1, 0, "d3_p4");
    sm_restart = 1'b1;
    cyc(0, 0, 1, "restart_pre");
    sm_restart = 1'b0;
    cyc(0, 0, 0, "restart_clr");

    // sideset 2: 0x1F & 7 = 7
    pc           = 5'd2;
    sideset_bits = 3'd2;
    cyc(1, 1, 0, "ss2_issue");
    for (int i = 0; i < 7; i++) cyc(1, 0, 1, "ss2_wait");
    cyc(1, 1, 0, "ss2_next");
    sm_restart = 1'b1;
    cyc(0, 0, 1, "ss2_restart");
    sm_restart   = 1'b0;
    sideset_bits = 3'd5;
    cyc(1, 1, 0, "ss5_a");
    cyc(1, 1, 0, "ss5_b");
    sideset_bits = 3'd7;
    cyc(1, 1, 0, "ss7_a");
    cyc(1, 1, 0, "ss7_b");
    penable      = 1'b0;
    sideset_bits = 3'd0;
    pc           = 5'd0;

    // forced instruction handshake
    imm_valid = 1'b1;
    imm_instr = 16'hA042;
    #1 chk("imm_rdy0", 16'(imm_ready), 16'd1);
    chk("imm_isimm0", 16'(is_imm), 16'd0);
    tick();
    imm_instr = 16'h1234;
    #1 chk("imm_rdy1", 16'(imm_ready), 16'd0);
    chk("imm_isimm1", 16'(is_imm), 16'd1);
    chk("imm_instr1", instr, 16'hA042);
    chk("imm_issue1", 16'(issue), 16'd1);
    tick();
    #1 chk("imm_rdy2", 16'(imm_ready), 16'd1);
    chk("imm_isimm2", 16'(is_imm), 16'd0);
    chk("imm_instr2", instr, 16'h0300);
    tick();
    imm_valid  = 1'b0;
    stalled_in = 1'b1;
    #1 chk("imm_stall_issue", 16'(issue), 16'd0);
    chk("imm_stall_instr", instr, 16'h1234);
    tick();
    stalled_in = 1'b0;
    #1 chk("imm_held", 16'(is_imm), 16'd1);
    chk("imm_held_issue", 16'(issue), 16'd1);
    tick();
    #1 chk("imm_done_rdy", 16'(imm_ready), 16'd1);

    // forced instruction in the middle of a delay
    cyc(1, 1, 0, "d2_issue");
    cyc(1, 0, 1, "d2_dec");
    penable   = 1'b0;
    imm_valid = 1'b1;
    imm_instr = 16'hA042;
    #1 chk("d2_acc_rdy", 16'(imm_ready), 16'd1);
    tick();
    imm_valid = 1'b0;
    #1 chk("d2_is_imm", 16'(is_imm), 16'd1);
    cyc(1, 1, 1, "d2_imm");
    cyc(1, 0, 1, "d2_p1");
    cyc(1, 0, 1, "d2_p2");
    cyc(1, 1, 0, "d2_resume");
    sm_restart = 1'b1;
    cyc(0, 0, 1, "d2_restart");

    // restart beats a same-cycle delay load
    pc = 5'd1;
    cyc(1, 1, 0, "rvl_issue");
    sm_restart = 1'b0;
    cyc(0, 0, 0, "rvl_won");
    cyc(1, 1, 0, "d4_issue");
    sm_restart = 1'b1;
    cyc(0, 0, 1, "d4_busy");
    sm_restart = 1'b0;
    cyc(0, 0, 0, "d4_cleared");

    // async reset mid-delay with a forced instruction pending
    cyc(1, 1, 0, "ar_issue");
    penable   = 1'b0;
    imm_valid = 1'b1;
    imm_instr = 16'hA042;
    tick();
    imm_valid = 1'b0;
    #1 chk("ar_pre_imm", 16'(is_imm), 16'd1);
    chk("ar_pre_busy", 16'(delay_busy), 16'd1);
    #1 reset_n = 1'b0;
    #1 chk("ar_ready", 16'(imm_ready), 16'd1);
    chk("ar_is_imm", 16'(is_imm), 16'd0);
    chk("ar_busy", 16'(delay_busy), 16'd0);
    chk("ar_issue", 16'(issue), 16'd0);
    chk("ar_instr", instr, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
